arp_rx: RTL and testbench
=========================

ARP_RX -- requirements
Module: arp_rx

Interface
REQ-001 Parameter BOARD_MAC, default 48'h00_11_22_33_44_55, local MAC address accepted as the frame destination.
REQ-002 Parameter BOARD_IP, default 32'hC0_A8_01_0A (192.168.1.10), local IP address that the ARP target-IP field must match.
REQ-003 clk  input  1  single system clock; GMII RX data is sampled on its rising edge.
REQ-004 sys_rst  input  1  reset, synchronous, active-high.
REQ-005 gmii_rx_dv  input  1  receive data valid, high for the whole frame.
REQ-006 gmii_rxd  input  8  receive byte, valid when gmii_rx_dv=1.
REQ-007 arp_rx_done  output  1  one-cycle pulse when a valid ARP packet addressed to BOARD_IP has been parsed.
REQ-008 arp_rx_type  output  1  type of the last accepted packet: 0=request, 1=reply; held between pulses.
REQ-009 src_mac  output  48  sender hardware address of the last accepted packet; held between pulses.
REQ-010 src_ip  output  32  sender protocol address of the last accepted packet; held between pulses.

Function
REQ-011 The FSM SHALL have five states: IDLE, PREAMBLE, ETH_HEAD, ARP_DATA and RX_END; one byte is consumed per clk cycle while gmii_rx_dv=1.
REQ-012 IDLE: the FSM SHALL go to PREAMBLE when dv=1 and rxd=0x55, and stay in IDLE otherwise.
REQ-013 PREAMBLE: the FSM SHALL require 6 further 0x55 bytes followed by 0xD5, then go to ETH_HEAD; any other byte goes to RX_END.
REQ-014 ETH_HEAD, 14 bytes: the destination MAC (bytes 0-5, MSB first) SHALL equal BOARD_MAC or 48'hFF_FF_FF_FF_FF_FF, and the type field (bytes 12-13) SHALL equal 16'h0806.
REQ-015 A destination or type mismatch in ETH_HEAD SHALL cause a transition to RX_END after the last header byte; on a match the FSM goes to ARP_DATA.
REQ-016 ARP_DATA, 28 bytes indexed 0-27, uses these fields:
- OPER = bytes 6-7
- SHA = bytes 8-13
- SPA = bytes 14-17
- TPA = bytes 24-27
- HTYPE, PTYPE, HLEN, PLEN and THA are ignored.
REQ-017 Acceptance SHALL require OPER equal to 16'h0001 (request → type 0) or 16'h0002 (reply → type 1), and TPA equal to BOARD_IP.
REQ-018 On acceptance, arp_rx_done SHALL pulse high for exactly one cycle, in the cycle after the edge that samples ARP byte 27.
- arp_rx_type, src_mac and src_ip SHALL update on that same edge.
- The FSM then goes to RX_END.
REQ-019 A rejected packet SHALL produce no pulse, SHALL leave all held outputs unchanged, and SHALL send the FSM to RX_END.
REQ-020 SHA and SPA SHALL be captured into shadow registers; the outputs SHALL load from the shadows only on acceptance.
REQ-021 RX_END SHALL discard padding, FCS and any remaining bytes, and SHALL go to IDLE on the first cycle with dv=0.
REQ-022 If gmii_rx_dv falls in PREAMBLE, ETH_HEAD or ARP_DATA, the FSM SHALL go to IDLE, produce no pulse, and leave the outputs unchanged.
REQ-023 The FCS SHALL NOT be checked.
REQ-024 Back-to-back frames separated by a single dv=0 cycle SHALL each be parsed.

Reset
REQ-025 While sys_rst=1 the block SHALL drive arp_rx_done=0, arp_rx_type=0, src_mac=0 and src_ip=0, clear the byte counter and shadow registers, and hold the FSM in RX_END.
REQ-026 After reset release the FSM SHALL stay in RX_END until gmii_rx_dv=0, so that a frame already in progress is never parsed.

Structure
REQ-027 A shared package arp_pkg SHALL hold the following, so that the ARP TX and control blocks reuse them:
- ETH_TYPE_ARP = 16'h0806
- ARP_OP_REQ = 16'h0001, ARP_OP_REPLY = 16'h0002
- PREAMBLE_BYTE = 8'h55, SFD_BYTE = 8'hD5
- ETH_HEAD_LEN = 14, ARP_LEN = 28
- the state encoding.
REQ-028 arp_rx SHALL be a single module with one FSM, one shared byte counter and no sub-modules.

Verification
REQ-029 Valid broadcast request frame: 7×0x55, 0xD5, dest FF×6, type 0806, OPER 0001, SHA 0A:0B:0C:0D:0E:0F, SPA C0A80102, TPA C0A8010A → one arp_rx_done pulse, arp_rx_type=0, src_mac=48'h0A0B0C0D0E0F, src_ip=32'hC0A80102, with the pulse in the cycle after TPA byte 3.
REQ-030 Unicast reply to BOARD_MAC with OPER 0002 → pulse, arp_rx_type=1.
REQ-031 Frames that must produce no pulse, with outputs keeping their previous values:
- TPA=C0A8010B
- dest MAC 00:11:22:33:44:66
- type 0800
- OPER 0003.
REQ-032 Mid-frame aborts:
- dv dropped at ARP byte 20 → no pulse, and an immediately following valid frame → pulse.
- sys_rst asserted at ARP byte 10 and released with dv still high → no pulse until dv goes low and a new valid frame arrives.
REQ-033 Two valid frames separated by 1 idle cycle → two pulses, 73 cycles apart for 64-byte frames.

Source files
------------

// File: rtl/arp_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | arp_pkg : constants and state encoding shared by the ARP RX/TX/ctrl blocks |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
package arp_pkg;

    localparam logic [15:0] ETH_TYPE_ARP  = 16'h0806;
    localparam logic [15:0] ARP_OP_REQ    = 16'h0001;
    localparam logic [15:0] ARP_OP_REPLY  = 16'h0002;
    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [4:0]  PREAMBLE_CNT  = 5'd6;
    localparam logic [4:0]  ETH_HEAD_LEN  = 5'd14;
    localparam logic [4:0]  ARP_LEN       = 5'd28;

    localparam int          STATE_W     = 3;
    localparam logic [2:0]  ST_IDLE     = 3'd0;
    localparam logic [2:0]  ST_PREAMBLE = 3'd1;
    localparam logic [2:0]  ST_ETH_HEAD = 3'd2;
    localparam logic [2:0]  ST_ARP_DATA = 3'd3;
    localparam logic [2:0]  ST_RX_END   = 3'd4;

    // Byte idx of a MAC address in wire order (0 = most significant).
    function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [2:0] idx);
        case (idx)
            3'd0:    mac_byte = mac[47:40];
            3'd1:    mac_byte = mac[39:32];
            3'd2:    mac_byte = mac[31:24];
            3'd3:    mac_byte = mac[23:16];
            3'd4:    mac_byte = mac[15:8];
            default: mac_byte = mac[7:0];
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/arp_rx.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | arp_rx : GMII receive parser that accepts ARP request/reply for BOARD_IP   |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module arp_rx
    import arp_pkg::*;
#(
    parameter logic [47:0] BOARD_MAC = 48'h00_11_22_33_44_55,
    parameter logic [31:0] BOARD_IP  = 32'hC0_A8_01_0A
) (
    input  logic        clk,
    input  logic        sys_rst,
    input  logic        gmii_rx_dv,
    input  logic [7:0]  gmii_rxd,
    output logic        arp_rx_done,
    output logic        arp_rx_type,
    output logic [47:0] src_mac,
    output logic [31:0] src_ip
);

    logic [STATE_W-1:0] state_q, state_d;
    logic [4:0]         cnt_q, cnt_d;
    logic               ucast_q, ucast_d, bcast_q, bcast_d, etype_ok_q, etype_ok_d;
    logic [15:0]        oper_q, oper_d;
    logic [47:0]        sha_q, sha_d;
    logic [31:0]        spa_q, spa_d;
    logic [23:0]        tpa_q, tpa_d;
    logic               done_q, done_d, rx_type_q, rx_type_d;
    logic [47:0]        mac_q, mac_d;
    logic [31:0]        ip_q, ip_d;

    logic w_head_ok, w_op_ok, w_accept;

    assign w_head_ok = (ucast_q | bcast_q) && etype_ok_q && (gmii_rxd == ETH_TYPE_ARP[7:0]);
    assign w_op_ok   = (oper_q == ARP_OP_REQ) || (oper_q == ARP_OP_REPLY);
    assign w_accept  = (state_q == ST_ARP_DATA) && gmii_rx_dv && (cnt_q == ARP_LEN - 5'd1)
                       && w_op_ok && ({tpa_q, gmii_rxd} == BOARD_IP);

    // Reset parks the FSM in RX_END so a frame already in flight is skipped.
    always_ff @(posedge clk) begin
        if (sys_rst) state_q <= ST_RX_END;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (gmii_rx_dv && gmii_rxd == PREAMBLE_BYTE) state_d = ST_PREAMBLE;
            end
            ST_PREAMBLE: begin
                if (!gmii_rx_dv)                                         state_d = ST_IDLE;
                else if (gmii_rxd == PREAMBLE_BYTE && cnt_q < PREAMBLE_CNT) state_d = ST_PREAMBLE;
                else if (gmii_rxd == SFD_BYTE && cnt_q == PREAMBLE_CNT)     state_d = ST_ETH_HEAD;
                else                                                     state_d = ST_RX_END;
            end
            ST_ETH_HEAD: begin
                if (!gmii_rx_dv)                           state_d = ST_IDLE;
                else if (cnt_q == ETH_HEAD_LEN - 5'd1)     state_d = w_head_ok ? ST_ARP_DATA : ST_RX_END;
            end
            ST_ARP_DATA: begin
                if (!gmii_rx_dv)                           state_d = ST_IDLE;
                else if (cnt_q == ARP_LEN - 5'd1)          state_d = ST_RX_END;
            end
            ST_RX_END: begin
                if (!gmii_rx_dv) state_d = ST_IDLE;
            end
            default: state_d = ST_RX_END;
        endcase
    end

    always_comb begin
        cnt_d      = cnt_q;
        ucast_d    = ucast_q;
        bcast_d    = bcast_q;
        etype_ok_d = etype_ok_q;
        oper_d     = oper_q;
        sha_d      = sha_q;
        spa_d      = spa_q;
        tpa_d      = tpa_q;
        done_d     = 1'b0;
        rx_type_d  = rx_type_q;
        mac_d      = mac_q;
        ip_d       = ip_q;
        case (state_q)
            ST_IDLE: cnt_d = 5'd0;
            ST_PREAMBLE: begin
                if (gmii_rx_dv) begin
                    cnt_d = cnt_q + 5'd1;
                    if (gmii_rxd == SFD_BYTE && cnt_q == PREAMBLE_CNT) begin
                        cnt_d      = 5'd0;
                        ucast_d    = 1'b1;
                        bcast_d    = 1'b1;
                        etype_ok_d = 1'b1;
                    end
                end
            end
            ST_ETH_HEAD: begin
                if (gmii_rx_dv) begin
                    cnt_d = (cnt_q == ETH_HEAD_LEN - 5'd1) ? 5'd0 : cnt_q + 5'd1;
                    if (cnt_q < 5'd6) begin
                        if (gmii_rxd != mac_byte(BOARD_MAC, cnt_q[2:0])) ucast_d = 1'b0;
                        if (gmii_rxd != 8'hFF)                          bcast_d = 1'b0;
                    end
                    if (cnt_q == 5'd12 && gmii_rxd != ETH_TYPE_ARP[15:8]) etype_ok_d = 1'b0;
                end
            end
            ST_ARP_DATA: begin
                if (gmii_rx_dv) begin
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd6)                       oper_d = {gmii_rxd, oper_q[7:0]};
                    if (cnt_q == 5'd7)                       oper_d = {oper_q[15:8], gmii_rxd};
                    if (cnt_q >= 5'd8 && cnt_q <= 5'd13)     sha_d  = {sha_q[39:0], gmii_rxd};
                    if (cnt_q >= 5'd14 && cnt_q <= 5'd17)    spa_d  = {spa_q[23:0], gmii_rxd};
                    if (cnt_q >= 5'd24 && cnt_q <= 5'd26)    tpa_d  = {tpa_q[15:0], gmii_rxd};
                    // Held outputs load from the shadows only when the packet is accepted.
                    if (w_accept) begin
                        done_d    = 1'b1;
                        rx_type_d = (oper_q == ARP_OP_REPLY);
                        mac_d     = sha_q;
                        ip_d      = spa_q;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (sys_rst) begin
            cnt_q      <= 5'd0;
            ucast_q    <= 1'b0;
            bcast_q    <= 1'b0;
            etype_ok_q <= 1'b0;
            oper_q     <= 16'd0;
            sha_q      <= 48'd0;
            spa_q      <= 32'd0;
            tpa_q      <= 24'd0;
            done_q     <= 1'b0;
            rx_type_q  <= 1'b0;
            mac_q      <= 48'd0;
            ip_q       <= 32'd0;
        end else begin
            cnt_q      <= cnt_d;
            ucast_q    <= ucast_d;
            bcast_q    <= bcast_d;
            etype_ok_q <= etype_ok_d;
            oper_q     <= oper_d;
            sha_q      <= sha_d;
            spa_q      <= spa_d;
            tpa_q      <= tpa_d;
            done_q     <= done_d;
            rx_type_q  <= rx_type_d;
            mac_q      <= mac_d;
            ip_q       <= ip_d;
        end
    end

    assign arp_rx_done = done_q;
    assign arp_rx_type = rx_type_q;
    assign src_mac     = mac_q;
    assign src_ip      = ip_q;

endmodule
`default_nettype wire

// File: tb/tb_arp_rx.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_arp_rx : directed frames against arp_rx with hand-computed results      |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module tb_arp_rx;

    logic        clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        gmii_rx_dv = 1'b0;
    logic [7:0]  gmii_rxd = 8'h00;
    logic        arp_rx_done;
    logic        arp_rx_type;
    logic [47:0] src_mac;
    logic [31:0] src_ip;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;
    int pulse_cnt = 0;
    int last_pulse = -1;
    int prev_pulse = -1;
    int tpa_cyc = 0;

    arp_rx dut (
        .clk         (clk),
        .sys_rst     (sys_rst),
        .gmii_rx_dv  (gmii_rx_dv),
        .gmii_rxd    (gmii_rxd),
        .arp_rx_done (arp_rx_done),
        .arp_rx_type (arp_rx_type),
        .src_mac     (src_mac),
        .src_ip      (src_ip)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (arp_rx_done === 1'b1) begin
            pulse_cnt  = pulse_cnt + 1;
            prev_pulse = last_pulse;
            last_pulse = cyc;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run = tests_run + 1;
        assert (obs === exp) else begin
            tests_failed = tests_failed + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // abort_arp / rst_arp: ARP byte index at which dv drops / reset asserts (-1 = never).
    task automatic send_frame(input logic [47:0] dst, input logic [15:0] etype,
                              input logic [15:0] oper, input logic [47:0] sha,
                              input logic [31:0] spa, input logic [31:0] tpa,
                              input int abort_arp, input int rst_arp, input int gap);
        logic [7:0] fr [72];
        bit aborted;
        for (int i = 0; i < 72; i++) fr[i] = i[7:0] ^ 8'hA5;
        for (int i = 0; i < 7; i++) fr[i] = 8'h55;
        fr[7] = 8'hD5;
        for (int i = 0; i < 6; i++) begin
            fr[8+i]  = dst[8*(5-i) +: 8];
            fr[14+i] = sha[8*(5-i) +: 8];
            fr[30+i] = sha[8*(5-i) +: 8];
            fr[40+i] = 8'h00;
        end
        fr[20] = etype[15:8]; fr[21] = etype[7:0];
        fr[22] = 8'h00; fr[23] = 8'h01; fr[24] = 8'h08; fr[25] = 8'h00;
        fr[26] = 8'h06; fr[27] = 8'h04;
        fr[28] = oper[15:8]; fr[29] = oper[7:0];
        for (int i = 0; i < 4; i++) begin
            fr[36+i] = spa[8*(3-i) +: 8];
            fr[46+i] = tpa[8*(3-i) +: 8];
        end
        aborted = 1'b0;
        for (int i = 0; i < 72; i++) begin
            if (!aborted) begin
                @(negedge clk);
                if (abort_arp >= 0 && i == 22 + abort_arp) begin
                    aborted    = 1'b1;
                    gmii_rx_dv = 1'b0;
                    gmii_rxd   = 8'h00;
                end else begin
                    if (rst_arp >= 0 && i == 22 + rst_arp)     sys_rst = 1'b1;
                    if (rst_arp >= 0 && i == 22 + rst_arp + 2) sys_rst = 1'b0;
                    gmii_rx_dv = 1'b1;
                    gmii_rxd   = fr[i];
                    if (i == 49) tpa_cyc = cyc;
                end
            end
        end
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            gmii_rx_dv = 1'b0;
            gmii_rxd   = 8'h00;
        end
    endtask

    localparam logic [47:0] BCAST = 48'hFF_FF_FF_FF_FF_FF;
    localparam logic [47:0] MYMAC = 48'h00_11_22_33_44_55;
    localparam logic [31:0] MYIP  = 32'hC0_A8_01_0A;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_done", {63'd0, arp_rx_done}, 64'd0);
        chk("rst_type", {63'd0, arp_rx_type}, 64'd0);
        chk("rst_mac",  {16'd0, src_mac}, 64'd0);
        chk("rst_ip",   {32'd0, src_ip}, 64'd0);
        sys_rst = 1'b0;
        repeat (2) @(negedge clk);

        // Broadcast request
        send_frame(BCAST, 16'h0806, 16'h0001, 48'h0A0B0C0D0E0F, 32'hC0A80102, MYIP, -1, -1, 3);
        chk("req_pulses",  pulse_cnt, 1);
        chk("req_latency", last_pulse, tpa_cyc + 1);
        chk("req_type",    {63'd0, arp_rx_type}, 64'd0);
        chk("req_mac",     {16'd0, src_mac}, 64'h0A0B0C0D0E0F);
        chk("req_ip",      {32'd0, src_ip}, 64'hC0A80102);

        // Unicast reply
        send_frame(MYMAC, 16'h0806, 16'h0002, 48'hA1A2A3A4A5A6, 32'hC0A80163, MYIP, -1, -1, 3);
        chk("rep_pulses",  pulse_cnt, 2);
        chk("rep_latency", last_pulse, tpa_cyc + 1);
        chk("rep_type",    {63'd0, arp_rx_type}, 64'd1);
        chk("rep_mac",     {16'd0, src_mac}, 64'hA1A2A3A4A5A6);
        chk("rep_ip",      {32'd0, src_ip}, 64'hC0A80163);

        // Rejects: wrong TPA, wrong dest MAC, wrong ethertype, bad OPER
        send_frame(BCAST, 16'h0806, 16'h0001, 48'h010203040506, 32'hC0A80104, 32'hC0A8010B, -1, -1, 2);
        chk("rej_tpa_pulses", pulse_cnt, 2);
        chk("rej_tpa_mac",    {16'd0, src_mac}, 64'hA1A2A3A4A5A6);
        send_frame(48'h001122334466, 16'h0806, 16'h0001, 48'h010203040506, 32'hC0A80104, MYIP, -1, -1, 2);
        chk("rej_dst_pulses", pulse_cnt, 2);
        chk("rej_dst_ip",     {32'd0, src_ip}, 64'hC0A80163);
        send_frame(BCAST, 16'h0800, 16'h0001, 48'h010203040506, 32'hC0A80104, MYIP, -1, -1, 2);
        chk("rej_type_pulses", pulse_cnt, 2);
        chk("rej_type_rxtype", {63'd0, arp_rx_type}, 64'd1);
        send_frame(MYMAC, 16'h0806, 16'h0003, 48'h010203040506, 32'hC0A80104, MYIP, -1, -1, 2);
        chk("rej_op_pulses", pulse_cnt, 2);
        chk("rej_op_mac",    {16'd0, src_mac}, 64'hA1A2A3A4A5A6);
        chk("rej_op_ip",     {32'd0, src_ip}, 64'hC0A80163);

        // dv drops at ARP byte 20, then a valid frame after one idle cycle
        send_frame(BCAST, 16'h0806, 16'h0001, 48'h111111111111, 32'hC0A80111, MYIP, 20, -1, 0);
        chk("abort_pulses", pulse_cnt, 2);
        chk("abort_mac",    {16'd0, src_mac}, 64'hA1A2A3A4A5A6);
        send_frame(BCAST, 16'h0806, 16'h0001, 48'hB0B1B2B3B4B5, 32'hC0A80177, MYIP, -1, -1, 2);
        chk("after_abort_pulses", pulse_cnt, 3);
        chk("after_abort_mac",    {16'd0, src_mac}, 64'hB0B1B2B3B4B5);
        chk("after_abort_type",   {63'd0, arp_rx_type}, 64'd0);

        // Reset at ARP byte 10, released while dv is still high
        send_frame(BCAST, 16'h0806, 16'h0001, 48'h222222222222, 32'hC0A80122, MYIP, -1, 10, 1);
        chk("midrst_pulses", pulse_cnt, 3);
        chk("midrst_mac",    {16'd0, src_mac}, 64'd0);
        chk("midrst_ip",     {32'd0, src_ip}, 64'd0);
        send_frame(MYMAC, 16'h0806, 16'h0002, 48'hC1C2C3C4C5C6, 32'hC0A80133, MYIP, -1, -1, 1);
        chk("postrst_pulses", pulse_cnt, 4);
        chk("postrst_mac",    {16'd0, src_mac}, 64'hC1C2C3C4C5C6);
        chk("postrst_type",   {63'd0, arp_rx_type}, 64'd1);

        // Back-to-back 64-byte frames with one idle cycle between them
        send_frame(BCAST, 16'h0806, 16'h0001, 48'hD0D1D2D3D4D5, 32'hC0A80144, MYIP, -1, -1, 1);
        send_frame(MYMAC, 16'h0806, 16'h0001, 48'hE0E1E2E3E4E5, 32'hC0A80155, MYIP, -1, -1, 3);
        chk("b2b_pulses",  pulse_cnt, 6);
        chk("b2b_spacing", last_pulse - prev_pulse, 73);
        chk("b2b_mac",     {16'd0, src_mac}, 64'hE0E1E2E3E4E5);
        chk("b2b_ip",      {32'd0, src_ip}, 64'hC0A80155);
        chk("idle_done",   {63'd0, arp_rx_done}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
